mem_requester: RTL and testbench

- Initiator-side controller that drives the word-addressed block-RAM memory port: write channel (in_*) and read channel (out_*).
- Accepts single-word load/store requests from the core, runs the memory's valid/ready handshake, and returns one response per request.
- Guarantees that write and read valid are never asserted together.
- Adds alignment/bounds checking and a watchdog timeout; sits between the core's load/store stage and the memory block.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_wait_timer.sv | 37 +++
 rtl/mem_requester.sv | 195 +++++++++++++++++++
 tb/tb_mem_requester.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory requester and the block-RAM it drives.
package mem_pkg;

  // Number of addressable 32-bit words in the block RAM.
  localparam int unsigned MEM_WORDS     = 655360;
  // Byte address bits below the word index.
  localparam int unsigned WORD_ADDR_LSB = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWrWait,
    StRdWait,
    StResp
  } state_e;

  // True when a byte address is word aligned and its word index lies inside the RAM.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned words = MEM_WORDS);
    logic [31:0] word_idx;
    word_idx = addr >> WORD_ADDR_LSB;
    return (addr[WORD_ADDR_LSB-1:0] == '0) && (word_idx < words);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory handshake; flags expiry on the last permitted cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TIMER_WIDTH    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_WIDTH-1:0] count_q, count_d;

  // Expired while the count sits on its final value, giving TIMEOUT_CYCLES wait cycles in total.
  assign expired = (count_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  // Next count: clear wins, then saturate at the expiry value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_requester.sv
// Initiator-side controller: turns single-word core load/store requests into the block-RAM
// valid/ready handshake, with alignment/bounds checking and a watchdog timeout.
module mem_requester #(
  parameter int unsigned MEM_WORDS      = mem_pkg::MEM_WORDS,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TIMER_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  // Core side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  // Memory write channel
  output logic [31:0] mem_in_addr,
  output logic [31:0] mem_in_data,
  output logic        mem_in_valid,
  input  logic        mem_in_ready,
  // Memory read channel
  output logic [31:0] mem_out_addr,
  output logic        mem_out_valid,
  input  logic [31:0] mem_out_data,
  input  logic        mem_out_ready,
  input  logic        mem_addr_error
);

  import mem_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        in_valid_q, in_valid_d;
  logic        out_valid_q, out_valid_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  // Rejected request: RESP is entered one cycle before its response pulse.
  logic        err_pend_q, err_pend_d;

  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;

  assign req_ready     = (state_q == StIdle);
  assign timer_enable  = (state_q == StWrWait) || (state_q == StRdWait);

  // The memory decodes the byte address itself, so both channels carry the latched byte address.
  assign mem_in_addr   = addr_q;
  assign mem_in_data   = wdata_q;
  assign mem_out_addr  = addr_q;
  assign mem_in_valid  = in_valid_q;
  assign mem_out_valid = out_valid_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_error     = rsp_error_q;
  assign rsp_timeout   = rsp_timeout_q;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_WIDTH   (TIMER_WIDTH)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // Next-state and registered-output logic; valid always drops on the edge that samples ready.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    in_valid_d    = in_valid_q;
    out_valid_d   = out_valid_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    err_pend_d    = err_pend_q;
    timer_clear   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          timer_clear = 1'b1;
          if (!addr_in_range(req_addr, MEM_WORDS)) begin
            err_pend_d = 1'b1;
            state_d    = StResp;
          end else if (req_write) begin
            in_valid_d = 1'b1;
            state_d    = StWrWait;
          end else begin
            out_valid_d = 1'b1;
            state_d     = StRdWait;
          end
        end
      end

      StWrWait: begin
        // Ready takes priority over a simultaneous timeout.
        if (mem_in_ready) begin
          in_valid_d    = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = mem_addr_error;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (timer_expired) begin
          in_valid_d    = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end
      end

      StRdWait: begin
        if (mem_out_ready) begin
          out_valid_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = mem_out_data;
          rsp_error_d   = mem_addr_error;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (timer_expired) begin
          out_valid_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end
      end

      StResp: begin
        if (err_pend_q) begin
          err_pend_d    = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b0;
        end else begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; asynchronous reset drops every valid immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      in_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      err_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      in_valid_q    <= in_valid_d;
      out_valid_q   <= out_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_pend_q    <= err_pend_d;
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester against a small block-RAM model that can be stalled.
module tb_mem_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [31:0] mem_in_addr;
  logic [31:0] mem_in_data;
  logic        mem_in_valid;
  logic        mem_in_ready;
  logic [31:0] mem_out_addr;
  logic        mem_out_valid;
  logic [31:0] mem_out_data;
  logic        mem_out_ready;
  logic        mem_addr_error = 1'b0;

  // Memory model state
  logic [31:0] mem_model [0:1023];
  logic        wr_ready = 1'b0;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data = '0;
  int          rd_cnt = 0;
  int          wr_strobes = 0;
  int          rd_strobes = 0;
  logic        stall = 1'b0;
  int          both_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  assign mem_in_ready  = wr_ready;
  assign mem_out_ready = rd_ready;
  assign mem_out_data  = rd_data;

  mem_requester #(
    .MEM_WORDS     (655360),
    .TIMEOUT_CYCLES(8),
    .TIMER_WIDTH   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .rsp_timeout   (rsp_timeout),
    .mem_in_addr   (mem_in_addr),
    .mem_in_data   (mem_in_data),
    .mem_in_valid  (mem_in_valid),
    .mem_in_ready  (mem_in_ready),
    .mem_out_addr  (mem_out_addr),
    .mem_out_valid (mem_out_valid),
    .mem_out_data  (mem_out_data),
    .mem_out_ready (mem_out_ready),
    .mem_addr_error(mem_addr_error)
  );

  always #5 clk = ~clk;

  // Write ready one cycle after valid; read ready three cycles after valid. Ready is a one-cycle
  // pulse and re-arms if valid stays high, so a lingering valid shows up as an extra strobe.
  always @(posedge clk) begin
    if (mem_in_valid && !wr_ready && !stall) begin
      wr_ready <= 1'b1;
      mem_model[mem_in_addr[11:2]] <= mem_in_data;
      wr_strobes <= wr_strobes + 1;
    end else begin
      wr_ready <= 1'b0;
    end
    if (mem_out_valid && !rd_ready && !stall) begin
      if (rd_cnt == 2) begin
        rd_ready   <= 1'b1;
        rd_data    <= mem_model[mem_out_addr[11:2]];
        rd_cnt     <= 0;
        rd_strobes <= rd_strobes + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end else begin
      rd_ready <= 1'b0;
      rd_cnt   <= 0;
    end
  end

  always @(negedge clk) begin
    if (mem_in_valid && mem_out_valid) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from just after a rising edge with the DUT idle; lat counts edges from
  // the accepting edge to the response, vcyc counts sampled cycles with a memory valid high.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input int exp_lat, input int exp_vcyc,
                         input logic [31:0] exp_rdata, input logic exp_err, input logic exp_tout);
    int          lat;
    int          vcyc;
    logic [31:0] rdata;
    logic        err;
    logic        tout;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat  = 0;
    vcyc = 0;
    while (!rsp_valid && lat < 40) begin
      if (mem_in_valid || mem_out_valid) vcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (mem_in_valid || mem_out_valid) vcyc++;
    rdata = rsp_rdata;
    err   = rsp_error;
    tout  = rsp_timeout;
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".vcyc"}, vcyc, exp_vcyc);
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, ".tout"}, {31'b0, tout}, {31'b0, exp_tout});
    @(posedge clk); #1;
    check({tag, ".rsp_pulse"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, ".ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  // Back-to-back stream bookkeeping
  logic        b_wr   [0:2];
  logic [31:0] b_addr [0:2];
  logic [31:0] b_data [0:2];
  int          acc_cyc [0:3];
  int          rsp_cyc [0:3];
  logic [31:0] rsp_dat [0:3];
  logic        rsp_err [0:3];

  initial begin
    int wr_before;
    int n_acc;
    int n_rsp;
    int seen;
    logic acc;

    // Reset state
    #12;
    check("rst.ready", {31'b0, req_ready}, 32'd1);
    check("rst.in_valid", {31'b0, mem_in_valid}, 32'd0);
    check("rst.out_valid", {31'b0, mem_out_valid}, 32'd0);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Store then load at word 4
    wr_before = wr_strobes;
    run_txn("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 2, 32'h0, 1'b0, 1'b0);
    check("st10.strobes", wr_strobes - wr_before, 32'd1);
    check("st10.mem", mem_model[4], 32'hDEAD_BEEF);
    run_txn("ld10", 1'b0, 32'h0000_0010, 32'h0, 4, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Rejected requests never reach memory
    run_txn("ld_misal", 1'b0, 32'h0000_0013, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0);
    run_txn("ld_oor", 1'b0, 32'h0028_0000, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0);

    // Last valid word
    run_txn("st_last", 1'b1, 32'h0027_FFFC, 32'hA5A5_0001, 2, 2, 32'h0, 1'b0, 1'b0);
    run_txn("ld_last", 1'b0, 32'h0027_FFFC, 32'h0, 4, 4, 32'hA5A5_0001, 1'b0, 1'b0);

    // Memory-reported address error
    mem_addr_error = 1'b1;
    run_txn("st_merr", 1'b1, 32'h0000_0040, 32'h1111_2222, 2, 2, 32'h0, 1'b1, 1'b0);
    mem_addr_error = 1'b0;

    // Memory never answers
    stall = 1'b1;
    wr_before = wr_strobes;
    run_txn("st_tout", 1'b1, 32'h0000_0030, 32'h3333_4444, 8, 8, 32'h0, 1'b0, 1'b1);
    check("st_tout.strobes", wr_strobes - wr_before, 32'd0);
    stall = 1'b0;
    run_txn("ld_after_tout", 1'b0, 32'h0000_0010, 32'h0, 4, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Back-to-back stream with req_valid held high
    b_wr[0] = 1'b1; b_addr[0] = 32'h0000_0020; b_data[0] = 32'h1234_5678;
    b_wr[1] = 1'b0; b_addr[1] = 32'h0000_0020; b_data[1] = 32'h0;
    b_wr[2] = 1'b1; b_addr[2] = 32'h0000_0024; b_data[2] = 32'hCAFE_F00D;
    n_acc = 0;
    n_rsp = 0;
    wr_before = wr_strobes;
    req_write = b_wr[0];
    req_addr  = b_addr[0];
    req_wdata = b_data[0];
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid && n_rsp < 4) begin
        rsp_cyc[n_rsp] = c;
        rsp_dat[n_rsp] = rsp_rdata;
        rsp_err[n_rsp] = rsp_error;
        n_rsp++;
      end
      acc = req_valid && req_ready;
      if (acc && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (n_acc < 3) begin
          req_write = b_wr[n_acc];
          req_addr  = b_addr[n_acc];
          req_wdata = b_data[n_acc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b.n_acc", n_acc, 32'd3);
    check("b2b.n_rsp", n_rsp, 32'd3);
    if (n_acc == 3 && n_rsp == 3) begin
      check("b2b.acc0", acc_cyc[0], 32'd0);
      check("b2b.acc1", acc_cyc[1], 32'd4);
      check("b2b.acc2", acc_cyc[2], 32'd10);
      check("b2b.rsp0", rsp_cyc[0], 32'd3);
      check("b2b.rsp1", rsp_cyc[1], 32'd9);
      check("b2b.rsp2", rsp_cyc[2], 32'd13);
      check("b2b.dat0", rsp_dat[0], 32'h0);
      check("b2b.dat1", rsp_dat[1], 32'h1234_5678);
      check("b2b.dat2", rsp_dat[2], 32'h0);
      check("b2b.err", {29'b0, rsp_err[0], rsp_err[1], rsp_err[2]}, 32'd0);
    end
    check("b2b.strobes", wr_strobes - wr_before, 32'd2);
    check("b2b.mem", mem_model[9], 32'hCAFE_F00D);

    // Reset during RD_WAIT
    req_write = 1'b0;
    req_addr  = 32'h0000_0010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstmid.pre_valid", {31'b0, mem_out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid.out_valid", {31'b0, mem_out_valid}, 32'd0);
    check("rstmid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstmid.ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("rstmid.no_rsp", seen, 32'd0);
    run_txn("ld_after_rst", 1'b0, 32'h0000_0010, 32'h0, 4, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);

    check("excl", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required completion before 200000");
    $fatal(1);
  end

endmodule
